// File: rtl/mini_alu_core.sv
// Two-stage fetch/execute microcontroller core: parametrised register file,
// logic/shift/branch opcodes, CALL/RET return stack, stall, HALT and sticky faults.
module mini_alu_core #(
   parameter int DATA_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int IP_WIDTH       = 8,
   parameter int STACK_DEPTH    = 4,
   parameter int LED_WIDTH      = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 iStall,
   input  logic [28:0]          iInstruction,
   output logic [IP_WIDTH-1:0]  oIP,
   output logic [LED_WIDTH-1:0] oLed,
   output logic                 oHalted,
   output logic                 oFault,
   output logic                 oIllegal
);

   localparam int NUM_REGS  = 1 << REG_ADDR_WIDTH;
   localparam int SP_WIDTH  = $clog2(STACK_DEPTH + 1);
   localparam int STK_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [IP_WIDTH-1:0]   IP_ONE   = IP_WIDTH'(1);
   localparam logic [SP_WIDTH-1:0]   SP_ONE   = SP_WIDTH'(1);
   localparam logic [SP_WIDTH-1:0]   SP_FULL  = SP_WIDTH'(STACK_DEPTH);
   localparam logic [DATA_WIDTH-1:0] DW_CONST = DATA_WIDTH'(DATA_WIDTH);

   typedef enum logic [4:0] {
      OP_NOP  = 5'd0,
      OP_ADD  = 5'd1,
      OP_SUB  = 5'd2,
      OP_STO  = 5'd3,
      OP_BLE  = 5'd4,
      OP_JMP  = 5'd5,
      OP_LED  = 5'd6,
      OP_AND  = 5'd7,
      OP_OR   = 5'd8,
      OP_XOR  = 5'd9,
      OP_SHL  = 5'd10,
      OP_SHR  = 5'd11,
      OP_BNE  = 5'd12,
      OP_CALL = 5'd13,
      OP_RET  = 5'd14,
      OP_HALT = 5'd15
   } opcode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   typedef struct packed {
      logic [4:0] op;
      logic [7:0] dest;
      logic [7:0] src1;
      logic [7:0] src0;
   } instr_t;

   state_e                  state_q, state_d;
   logic [IP_WIDTH-1:0]     ip_q;
   logic [IP_WIDTH-1:0]     dec_ip_q;
   instr_t                  dec_q;
   logic [DATA_WIDTH-1:0]   rf_q [NUM_REGS];
   logic [IP_WIDTH-1:0]     stack_q [STACK_DEPTH];
   logic [SP_WIDTH-1:0]     sp_q, sp_d;
   logic [LED_WIDTH-1:0]    led_q;
   logic                    fault_q;
   logic                    illegal_q;

   logic                    exec_en;
   logic                    fetch_en;
   logic [REG_ADDR_WIDTH-1:0] rd_addr, rs1_addr, rs0_addr;
   logic [DATA_WIDTH-1:0]   rs1, rs0, imm, shamt;
   logic [IP_WIDTH-1:0]     dest_ip;
   logic [STK_IDX_W-1:0]    push_idx, pop_idx;

   logic                    wr_en;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic                    led_en;
   logic                    push_en;
   logic                    pop_en;
   logic                    branch_en;
   logic [IP_WIDTH-1:0]     branch_target;
   logic                    fault_set;
   logic                    illegal_set;
   logic                    halt_exec;

   // Operand fetch from the decode register
   assign rd_addr  = dec_q.dest[REG_ADDR_WIDTH-1:0];
   assign rs1_addr = dec_q.src1[REG_ADDR_WIDTH-1:0];
   assign rs0_addr = dec_q.src0[REG_ADDR_WIDTH-1:0];
   assign rs1      = rf_q[rs1_addr];
   assign rs0      = rf_q[rs0_addr];
   assign imm      = DATA_WIDTH'({dec_q.src1, dec_q.src0});
   assign shamt    = rs0 % DW_CONST;
   assign dest_ip  = IP_WIDTH'(dec_q.dest);
   assign push_idx = STK_IDX_W'(sp_q);
   assign pop_idx  = STK_IDX_W'(sp_q - SP_ONE);

   // A stalled or halted core executes nothing; HALT itself also suppresses the fetch.
   assign exec_en  = (state_q == ST_RUN) && !iStall;
   assign fetch_en = exec_en && !halt_exec;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
      wr_en         = 1'b0;
      wr_data       = '0;
      led_en        = 1'b0;
      push_en       = 1'b0;
      pop_en        = 1'b0;
      branch_en     = 1'b0;
      branch_target = dest_ip;
      fault_set     = 1'b0;
      illegal_set   = 1'b0;
      halt_exec     = 1'b0;
      case (dec_q.op)
         OP_NOP:  ;
         OP_ADD:  begin wr_en = 1'b1; wr_data = rs1 + rs0; end
         OP_SUB:  begin wr_en = 1'b1; wr_data = rs1 - rs0; end
         OP_STO:  begin wr_en = 1'b1; wr_data = imm;       end
         OP_BLE:  branch_en = (rs1 <= rs0);
         OP_JMP:  branch_en = 1'b1;
         OP_LED:  led_en = 1'b1;
         OP_AND:  begin wr_en = 1'b1; wr_data = rs1 & rs0; end
         OP_OR:   begin wr_en = 1'b1; wr_data = rs1 | rs0; end
         OP_XOR:  begin wr_en = 1'b1; wr_data = rs1 ^ rs0; end
         OP_SHL:  begin wr_en = 1'b1; wr_data = rs1 << shamt; end
         OP_SHR:  begin wr_en = 1'b1; wr_data = rs1 >> shamt; end
         OP_BNE:  branch_en = (rs1 != rs0);
         OP_CALL: begin
            if (sp_q == SP_FULL) begin
               fault_set = 1'b1;
            end else begin
               push_en   = 1'b1;
               branch_en = 1'b1;
            end
         end
         OP_RET: begin
            if (sp_q == '0) begin
               fault_set = 1'b1;
            end else begin
               pop_en        = 1'b1;
               branch_en     = 1'b1;
               branch_target = stack_q[pop_idx];
            end
         end
         OP_HALT: halt_exec = 1'b1;
         default: illegal_set = 1'b1;
      endcase
   end

   always_comb begin
      sp_d = sp_q;
      if (push_en) begin
         sp_d = sp_q + SP_ONE;
      end else if (pop_en) begin
         sp_d = sp_q - SP_ONE;
      end
   end

   // Run/halt state machine: register, next state, outputs
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (exec_en && halt_exec) begin
         state_d = ST_HALT;
      end
   end

   always_comb begin
      oHalted = (state_q == ST_HALT);
      oIP     = (exec_en && branch_en) ? branch_target : ip_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ip_q      <= '0;
         dec_ip_q  <= '0;
         dec_q     <= '0;
         sp_q      <= '0;
         led_q     <= '0;
         fault_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (fetch_en) begin
            ip_q     <= oIP + IP_ONE;
            dec_ip_q <= oIP;
            dec_q    <= iInstruction;
         end
         if (exec_en) begin
            sp_q      <= sp_d;
            fault_q   <= fault_q | fault_set;
            illegal_q <= illegal_q | illegal_set;
            if (led_en) begin
               led_q <= rs1[LED_WIDTH-1:0];
            end
         end
      end
   end

   // NOTE: the register file is reset because programs may read any register before writing it;
   // the return stack is not, since SP guards every read of it.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (exec_en && wr_en) begin
         rf_q[rd_addr] <= wr_data;
      end
   end

   always_ff @(posedge Clock) begin
      if (exec_en && push_en) begin
         stack_q[push_idx] <= dec_ip_q + IP_ONE;
      end
   end

   assign oLed     = led_q;
   assign oFault   = fault_q;
   assign oIllegal = illegal_q;

endmodule

// File: tb/tb_mini_alu_core.sv
// Bench for mini_alu_core: an instruction-level model of the core is stepped
// alongside the DUT every cycle, plus hand-computed expectations per program.
module tb_mini_alu_core;

   localparam int SD = 4;

   localparam logic [4:0] NOP = 5'd0,  ADD = 5'd1,  SUB = 5'd2,  STO = 5'd3,
                          BLE = 5'd4,  LED = 5'd6,  AND = 5'd7,  ORR = 5'd8,
                          XOR = 5'd9,  SHL = 5'd10, SHR = 5'd11, BNE = 5'd12,
                          CALL = 5'd13, RET = 5'd14, HALT = 5'd15, ILL = 5'd20;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        iStall = 1'b0;
   logic [28:0] iInstruction;
   logic [7:0]  oIP;
   logic [7:0]  oLed;
   logic        oHalted, oFault, oIllegal;

   logic [28:0] rom [256];
   assign iInstruction = rom[oIP];

   always #5 Clock = ~Clock;

   mini_alu_core dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .iStall       (iStall),
      .iInstruction (iInstruction),
      .oIP          (oIP),
      .oLed         (oLed),
      .oHalted      (oHalted),
      .oFault       (oFault),
      .oIllegal     (oIllegal)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Architectural model: instruction being executed, next fetch address, state.
   logic [15:0] m_rf [16];
   logic [7:0]  m_stack [$];
   logic [7:0]  m_ip, m_cur_ip, m_led;
   logic [28:0] m_cur;
   logic        m_halted, m_fault, m_illegal;
   logic [7:0]  seen_ip;
   int          fetch3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [28:0] enc(input logic [4:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s0);
      return {op, d, s1, s0};
   endfunction

   function automatic void model_eval(output bit taken, output logic [7:0] tgt);
      logic [15:0] a;
      logic [15:0] b;
      a = m_rf[m_cur[11:8]];
      b = m_rf[m_cur[3:0]];
      taken = 1'b0;
      tgt = m_cur[23:16];
      case (m_cur[28:24])
         5'd4:  taken = (a <= b);
         5'd5:  taken = 1'b1;
         5'd12: taken = (a != b);
         5'd13: taken = (m_stack.size() < SD);
         5'd14: begin
            taken = (m_stack.size() > 0);
            if (taken) tgt = m_stack[$];
         end
         default: ;
      endcase
   endfunction

   function automatic logic [7:0] model_ip(input bit s);
      bit t;
      logic [7:0] g;
      model_eval(t, g);
      return (!m_halted && !s && t) ? g : m_ip;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_stack.delete();
      m_ip = '0; m_cur_ip = '0; m_cur = '0; m_led = '0;
      m_halted = 1'b0; m_fault = 1'b0; m_illegal = 1'b0;
   endtask

   task automatic model_step(input bit s);
      bit t;
      logic [7:0] g, fa;
      logic [3:0] rd;
      logic [15:0] a, b;
      if (m_halted || s) return;
      model_eval(t, g);
      rd = m_cur[19:16];
      a  = m_rf[m_cur[11:8]];
      b  = m_rf[m_cur[3:0]];
      case (m_cur[28:24])
         5'd1:  m_rf[rd] = a + b;
         5'd2:  m_rf[rd] = a - b;
         5'd3:  m_rf[rd] = m_cur[15:0];
         5'd6:  m_led = a[7:0];
         5'd7:  m_rf[rd] = a & b;
         5'd8:  m_rf[rd] = a | b;
         5'd9:  m_rf[rd] = a ^ b;
         5'd10: m_rf[rd] = a << (b % 16);
         5'd11: m_rf[rd] = a >> (b % 16);
         5'd13: if (t) m_stack.push_back(m_cur_ip + 8'd1); else m_fault = 1'b1;
         5'd14: if (t) void'(m_stack.pop_back()); else m_fault = 1'b1;
         5'd15: m_halted = 1'b1;
         default: if (m_cur[28:24] >= 5'd16) m_illegal = 1'b1;
      endcase
      if (m_halted) return;
      fa = t ? g : m_ip;
      m_cur = rom[fa];
      m_cur_ip = fa;
      m_ip = fa + 8'd1;
   endtask

   // One clock cycle: drive stall, compare all outputs with the model, advance the model.
   task automatic step(input bit s);
      @(negedge Clock);
      iStall = s;
      #1;
      check("oIP", oIP, model_ip(s));
      check("oLed", oLed, m_led);
      check("oHalted", oHalted, m_halted);
      check("oFault", oFault, m_fault);
      check("oIllegal", oIllegal, m_illegal);
      seen_ip = oIP;
      if (oIP == 8'd3) fetch3++;
      @(posedge Clock);
      model_step(s);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      iStall = 1'b0;
      model_reset();
      repeat (2) @(posedge Clock);
      #2 Reset = 1'b1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = enc(NOP, 0, 0, 0);
   endtask

   task automatic load_arith();
      clear_rom();
      rom[0]  = enc(STO, 1, 0, 5);
      rom[1]  = enc(STO, 2, 0, 3);
      rom[2]  = enc(SUB, 3, 1, 2);
      rom[3]  = enc(LED, 0, 3, 0);
      rom[4]  = enc(STO, 4, 8'hFF, 8'hFF);
      rom[5]  = enc(STO, 5, 0, 1);
      rom[6]  = enc(ADD, 6, 4, 5);
      rom[7]  = enc(BNE, 30, 6, 0);
      rom[8]  = enc(STO, 7, 0, 8'hF0);
      rom[9]  = enc(STO, 9, 0, 8'h3C);
      rom[10] = enc(AND, 8, 7, 9);
      rom[11] = enc(ORR, 10, 7, 9);
      rom[12] = enc(XOR, 11, 7, 9);
      rom[13] = enc(LED, 0, 8, 0);
      rom[14] = enc(LED, 0, 10, 0);
      rom[15] = enc(LED, 0, 11, 0);
      rom[16] = enc(BNE, 30, 11, 0);
      rom[17] = enc(HALT, 0, 0, 0);
      rom[30] = enc(HALT, 0, 0, 0);
   endtask

   task automatic load_loop();
      clear_rom();
      rom[0] = enc(STO, 1, 0, 0);
      rom[1] = enc(STO, 2, 0, 3);
      rom[2] = enc(STO, 3, 0, 1);
      rom[3] = enc(ADD, 1, 1, 3);
      rom[4] = enc(LED, 0, 1, 0);
      rom[5] = enc(BLE, 3, 1, 2);
      rom[6] = enc(HALT, 0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      fetch3 = 0;
      seen_ip = '0;
      clear_rom();

      // Arithmetic, logic, LED and wrap; then HALT freeze with stall ignored
      load_arith();
      do_reset();
      #1;
      check("reset_oIP", oIP, 8'd0);
      check("reset_oLed", oLed, 8'd0);
      run(5);
      check("lit_sub_led", oLed, 8'h02);
      run(10);
      check("lit_and_led", oLed, 8'h30);
      run(2);
      check("lit_xor_led", oLed, 8'hCC);
      run(2);
      check("lit_halted", oHalted, 1'b1);
      check("lit_halt_ip", oIP, 8'd31);
      for (int i = 0; i < 10; i++) step(i[0]);
      check("lit_halt_frozen_ip", oIP, 8'd31);

      // Same program with a 3-cycle stall while the taken BNE sits in execute
      do_reset();
      run(17);
      repeat (3) step(1'b1);
      check("lit_stall_ip", oIP, 8'd17);
      check("lit_stall_led", oLed, 8'hCC);
      run(2);
      check("lit_stall_halted", oHalted, 1'b1);
      check("lit_stall_halt_ip", oIP, 8'd31);

      // Counted loop: body executes 4 times, no bubbles
      load_loop();
      do_reset();
      fetch3 = 0;
      run(16);
      check("lit_loop_not_halted", oHalted, 1'b0);
      run(1);
      check("lit_loop_halted", oHalted, 1'b1);
      check("lit_loop_body_count", fetch3, 4);
      check("lit_loop_led", oLed, 8'h04);

      // Asynchronous reset in the middle of the loop, then a clean rerun
      do_reset();
      run(8);
      check("lit_pre_reset_led", oLed, 8'h01);
      #2 Reset = 1'b0;
      #1;
      check("async_rst_oIP", oIP, 8'd0);
      check("async_rst_oLed", oLed, 8'd0);
      check("async_rst_flags", {oHalted, oFault, oIllegal}, 3'b000);
      do_reset();
      run(17);
      check("lit_rerun_halted", oHalted, 1'b1);
      check("lit_rerun_led", oLed, 8'h04);

      // CALL/RET, then nested CALLs overflowing the return stack
      clear_rom();
      rom[0]  = enc(CALL, 10, 0, 0);
      rom[1]  = enc(LED, 0, 1, 0);
      rom[2]  = enc(CALL, 20, 0, 0);
      rom[3]  = enc(HALT, 0, 0, 0);
      rom[10] = enc(STO, 1, 0, 8'h11);
      rom[11] = enc(RET, 0, 0, 0);
      rom[20] = enc(CALL, 21, 0, 0);
      rom[21] = enc(CALL, 22, 0, 0);
      rom[22] = enc(CALL, 23, 0, 0);
      rom[23] = enc(CALL, 24, 0, 0);
      rom[24] = enc(STO, 2, 0, 8'h22);
      rom[25] = enc(LED, 0, 2, 0);
      rom[26] = enc(HALT, 0, 0, 0);
      do_reset();
      run(4);
      check("lit_ret_resume", seen_ip, 8'd1);
      run(1);
      check("lit_sub_led_11", oLed, 8'h11);
      run(4);
      check("lit_no_fault_yet", oFault, 1'b0);
      run(1);
      check("lit_overflow_fault", oFault, 1'b1);
      run(3);
      check("lit_overflow_led", oLed, 8'h22);
      check("lit_overflow_halt_ip", oIP, 8'd27);

      // RET on an empty stack faults and falls through
      clear_rom();
      rom[0] = enc(RET, 0, 0, 0);
      rom[1] = enc(HALT, 0, 0, 0);
      do_reset();
      run(2);
      check("lit_underflow_fault", oFault, 1'b1);
      check("lit_underflow_ip", oIP, 8'd2);
      run(3);
      check("lit_underflow_halted", oHalted, 1'b1);

      // Shifts with modulo shift amount, then an illegal opcode
      clear_rom();
      rom[0]  = enc(STO, 1, 0, 1);
      rom[1]  = enc(STO, 4, 0, 15);
      rom[2]  = enc(SHL, 3, 1, 4);
      rom[3]  = enc(STO, 6, 0, 8);
      rom[4]  = enc(SHR, 5, 3, 6);
      rom[5]  = enc(LED, 0, 5, 0);
      rom[6]  = enc(STO, 8, 0, 16);
      rom[7]  = enc(SHR, 7, 1, 8);
      rom[8]  = enc(LED, 0, 7, 0);
      rom[9]  = enc(ILL, 7, 1, 1);
      rom[10] = enc(LED, 0, 7, 0);
      rom[11] = enc(HALT, 0, 0, 0);
      do_reset();
      run(7);
      check("lit_shl15_led", oLed, 8'h80);
      run(3);
      check("lit_shr16_led", oLed, 8'h01);
      check("lit_no_illegal_yet", oIllegal, 1'b0);
      run(1);
      check("lit_illegal", oIllegal, 1'b1);
      run(1);
      check("lit_illegal_no_write", oLed, 8'h01);
      run(3);
      check("lit_shift_halted", oHalted, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
